// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one-word output slot, one-word skid buffer, branch redirect with stale-response drop.
// Optional build macro IF_PERF_CNT_EN adds the saturating stall_cnt output.
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] BranchAddr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        valid,
    output logic [31:0] instruction,
    output logic [31:0] PC
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {FETCH, WAIT, SKID, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] skid_data;
    logic [31:0] pc_next;
    logic        slot_free;
    logic        ack;

    assign pc_next   = pc + 32'd4;
    assign slot_free = !valid || !freeze;
    assign ack       = mem_ack && mem_req;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = (state == DROP) ? req_addr : pc;
        case (state)
            FETCH: mem_req = slot_free && !Branch_taken;
            WAIT:  mem_req = 1'b1;
            SKID:  mem_req = 1'b0;
            DROP:  mem_req = 1'b1;
            default: mem_req = 1'b0;
        endcase
        // The request must be low while reset is held, even though state already reads FETCH.
        if (!rst) mem_req = 1'b0;
    end

    // NOTE: state uses non-blocking assignments; a later load of valid overrides the earlier consume clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= 32'd0;
            req_addr    <= 32'd0;
            skid_data   <= 32'd0;
            valid       <= 1'b0;
            instruction <= 32'd0;
            PC          <= 32'd0;
        end else if (Branch_taken) begin
            pc    <= BranchAddr;
            valid <= 1'b0;
            case (state)
                WAIT: begin
                    if (ack) begin
                        state <= FETCH;
                    end else begin
                        state    <= DROP;
                        req_addr <= pc;
                    end
                end
                DROP:    state <= DROP;
                default: state <= FETCH;
            endcase
        end else begin
            if (valid && !freeze) valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (ack) begin
                        valid       <= 1'b1;
                        instruction <= mem_rdata;
                        PC          <= pc_next;
                        pc          <= pc_next;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        pc <= pc_next;
                        if (slot_free) begin
                            valid       <= 1'b1;
                            instruction <= mem_rdata;
                            PC          <= pc_next;
                            state       <= FETCH;
                        end else begin
                            skid_data <= mem_rdata;
                            state     <= SKID;
                        end
                    end
                end
                SKID: begin
                    // pc already points past the skid word, so it is that word's PC output.
                    if (slot_free) begin
                        valid       <= 1'b1;
                        instruction <= skid_data;
                        PC          <= pc;
                        state       <= FETCH;
                    end
                end
                DROP: begin
                    if (ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
        end else if (mem_req && !mem_ack && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately when rst is low, regardless of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 freeze  input  1  hazard stall from ID; when high, the ID side does not consume the current fetch output.
REQ-005 Branch_taken  input  1  redirect request from EXE.
REQ-006 BranchAddr  input  32  redirect target, word-aligned.
REQ-007 mem_req  output  1  instruction memory read request.
REQ-008 mem_addr  output  32  instruction memory byte address.
REQ-009 mem_ack  input  1  read data valid this cycle; only meaningful while mem_req is high.
REQ-010 mem_rdata  input  32  instruction word.
REQ-011 valid  output  1  instruction/PC outputs hold a live fetch.
REQ-012 instruction  output  32  fetched word, to the IF/ID register.
REQ-013 PC  output  32  fetch address + 4 of the word in instruction.

Function
REQ-014 Internal fetch pointer pc SHALL advance by 4 modulo 2^32 on each accepted word; 0xFFFFFFFC wraps to 0x00000000.
REQ-015 The output slot SHALL be consumed in a cycle where valid=1 and freeze=0.
REQ-016 The slot SHALL be free when valid=0 or it is consumed that cycle.
REQ-017 The FSM SHALL have exactly four states: FETCH, WAIT, SKID, DROP.
REQ-018 FETCH: mem_req = slot free; mem_addr = pc; on ack, load slot (instruction=mem_rdata, PC=pc+4, valid=1 next cycle) and stay in FETCH; with no ack, go to WAIT.
REQ-019 WAIT: mem_req=1 and mem_addr held stable until ack; on ack with slot free, load slot and go to FETCH; on ack with slot full, store the word in the skid register and go to SKID.
REQ-020 SKID: mem_req=0; when the slot frees, move the skid word into the slot and go to FETCH.
REQ-021 DROP: mem_req=1 at the stale address until ack; discard mem_rdata; go to FETCH.
REQ-022 Branch_taken SHALL have priority over freeze and all FSM transitions.
REQ-023 On Branch_taken, next cycle: pc=BranchAddr, valid=0, skid emptied.
REQ-024 Branch_taken in WAIT without same-cycle ack SHALL move the FSM to DROP; with a same-cycle ack, the word is discarded and the FSM goes to FETCH.
REQ-025 Branch_taken in DROP SHALL update pc and stay in DROP.
REQ-026 Throughput with zero-wait memory and no freeze SHALL be one word per cycle; fetch-to-valid latency SHALL be 1 cycle after ack.
REQ-027 Outputs SHALL hold unchanged while valid=1 and freeze=1.

Reset
REQ-028 Reset values: pc=0, state=FETCH, valid=0, instruction=0, PC=0, skid empty, mem_req=0 during reset.
REQ-029 Reset asserted mid-request SHALL abandon the request; the first post-reset request SHALL be to address 0.

Configuration
REQ-030 Macro IF_PERF_CNT_EN: when defined, add output stall_cnt (32 bits, reset 0) counting cycles with mem_req=1 and mem_ack=0, saturating at 0xFFFFFFFF.
REQ-031 Without IF_PERF_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Zero-wait memory, freeze=0 -> PC outputs 4, 8, 12, ... on consecutive cycles; instruction equals mem_rdata for 0, 4, 8.
REQ-033 Ack delayed 3 cycles at addr 0x10 -> mem_addr stable at 0x10 for all 4 request cycles; valid rises 1 cycle after ack with PC=0x14.
REQ-034 freeze asserted while ack arrives in WAIT -> word held in SKID; after freeze drops, outputs show the held word, then the skid word, with no loss or duplication.
REQ-035 Branch_taken with BranchAddr=0x100 while a request is pending in WAIT -> stale ack discarded; next valid word has PC=0x104.
REQ-036 pc=0xFFFFFFFC fetched -> PC output=0x00000000 and next mem_addr=0x00000000; rst pulsed low mid-WAIT -> valid=0 immediately and next request is to address 0.
